// File: rtl/lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : lsu_pkg                                              |
// | Description : Shared encodings for the EX/MEM load/store stage:    |
// |               result-select codes, funct3 access sizes and the     |
// |               LSU FSM state encoding.                              |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package lsu_pkg;

   // Write-back result source
   localparam logic [1:0] c_res_alu  = 2'b00;
   localparam logic [1:0] c_res_load = 2'b01;
   localparam logic [1:0] c_res_pc4  = 2'b10;

   // funct3 access size/sign for loads
   localparam logic [2:0] c_f3_lb  = 3'b000;
   localparam logic [2:0] c_f3_lh  = 3'b001;
   localparam logic [2:0] c_f3_lw  = 3'b010;
   localparam logic [2:0] c_f3_lbu = 3'b100;
   localparam logic [2:0] c_f3_lhu = 3'b101;

   // funct3 access size for stores
   localparam logic [2:0] c_f3_sb  = 3'b000;
   localparam logic [2:0] c_f3_sh  = 3'b001;
   localparam logic [2:0] c_f3_sw  = 3'b010;

   // LSU FSM states
   localparam logic [1:0] c_st_idle = 2'b00;
   localparam logic [1:0] c_st_req  = 2'b01;
   localparam logic [1:0] c_st_wait = 2'b10;
   localparam logic [1:0] c_st_done = 2'b11;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : lsu_align                                            |
// | Description : Combinational lane logic for the LSU: store strobes  |
// |               and replicated data, load lane select and extension, |
// |               and the alignment check for the incoming access.     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module lsu_align
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [1:0]            chk_addr_lo,
   input  logic [2:0]            chk_funct3,
   input  logic [1:0]            addr_lo,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] store_data,
   input  logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  misaligned,
   output logic [3:0]            wstrb,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] load_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Alignment check on the access about to be captured
   always_comb begin
      misaligned = 1'b0;
      case (chk_funct3)
         c_f3_lh, c_f3_lhu: misaligned = chk_addr_lo[0];
         c_f3_lw:           misaligned = (chk_addr_lo != 2'b00);
         default:           misaligned = 1'b0;
      endcase
   end

   // Store byte enables and lane-replicated write data
   always_comb begin
      wstrb = 4'hF;
      wdata = store_data;
      case (funct3[1:0])
         c_f3_sb[1:0]: begin
            wstrb = 4'b0001 << addr_lo;
            wdata = {4{store_data[7:0]}};
         end
         c_f3_sh[1:0]: begin
            wstrb = 4'b0011 << {addr_lo[1], 1'b0};
            wdata = {2{store_data[15:0]}};
         end
         default: begin
            wstrb = 4'hF;
            wdata = store_data;
         end
      endcase
   end

   // Load lane select followed by sign/zero extension
   always_comb begin
      case (addr_lo)
         2'b00:   w_byte = rsp_rdata[7:0];
         2'b01:   w_byte = rsp_rdata[15:8];
         2'b10:   w_byte = rsp_rdata[23:16];
         default: w_byte = rsp_rdata[31:24];
      endcase
      w_half = addr_lo[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
      case (funct3)
         c_f3_lb:  load_data = {{24{w_byte[7]}}, w_byte};
         c_f3_lbu: load_data = {24'd0, w_byte};
         c_f3_lh:  load_data = {{16{w_half[15]}}, w_half};
         c_f3_lhu: load_data = {16'd0, w_half};
         default:  load_data = rsp_rdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : mem_stage_lsu                                        |
// | Description : EX/MEM pipeline register with a load/store unit that |
// |               drives a valid/ready data-memory bus and stalls the  |
// |               pipeline while an access is outstanding.             |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module mem_stage_lsu
   import lsu_pkg::*;
#(
   parameter int DATA_WIDTH          = 32,
   parameter int DATA_ADDR_WIDTH     = 32,
   parameter int INST_ADDR_WIDTH     = 32,
   parameter int REGISTER_ADDR_WIDTH = 5
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [DATA_WIDTH-1:0]          alu_res_EX,
   input  logic [DATA_WIDTH-1:0]          write_data_EX,
   input  logic [REGISTER_ADDR_WIDTH-1:0] rd_EX,
   input  logic                           reg_write_EX,
   input  logic                           mem_write_EX,
   input  logic [1:0]                     result_sel_EX,
   input  logic [2:0]                     funct3_EX,
   input  logic [INST_ADDR_WIDTH-1:0]     PC_plus_4_EX,
   input  logic                           flush_EX_MEM,
   output logic [DATA_WIDTH-1:0]          alu_res_EX_MEM_o,
   output logic [REGISTER_ADDR_WIDTH-1:0] rd_EX_MEM_o,
   output logic                           reg_write_EX_MEM_o,
   output logic [1:0]                     result_sel_EX_MEM_o,
   output logic [INST_ADDR_WIDTH-1:0]     PC_plus_4_EX_MEM_o,
   output logic [DATA_WIDTH-1:0]          load_data_MEM,
   output logic                           misaligned_MEM,
   output logic                           stall_mem,
   output logic                           dmem_req_valid,
   input  logic                           dmem_req_ready,
   output logic                           dmem_req_we,
   output logic [DATA_ADDR_WIDTH-1:0]     dmem_req_addr,
   output logic [DATA_WIDTH-1:0]          dmem_req_wdata,
   output logic [3:0]                     dmem_req_wstrb,
   input  logic                           dmem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]          dmem_rsp_rdata
);

   logic [DATA_WIDTH-1:0]          r_alu_res;
   logic [DATA_WIDTH-1:0]          r_store_data;
   logic [REGISTER_ADDR_WIDTH-1:0] r_rd;
   logic                           r_reg_write;
   logic [1:0]                     r_result_sel;
   logic [INST_ADDR_WIDTH-1:0]     r_pc4;
   logic [2:0]                     r_funct3;
   logic                           r_is_load;
   logic                           r_is_store;
   logic                           r_misaligned;
   logic [DATA_WIDTH-1:0]          r_load_data;
   logic [1:0]                     r_state;
   logic [1:0]                     w_state_next;

   logic                           w_stall;
   logic                           w_capture;
   logic                           w_req;
   logic                           w_is_load_ex;
   logic                           w_memop_ex;
   logic                           w_mis_ex;
   logic [3:0]                     w_wstrb;
   logic [DATA_WIDTH-1:0]          w_wdata;
   logic [DATA_WIDTH-1:0]          w_load_data;

   assign w_stall      = (r_state == c_st_req) || (r_state == c_st_wait);
   assign w_capture    = !w_stall;
   assign w_req        = (r_state == c_st_req);
   assign w_is_load_ex = (result_sel_EX == c_res_load);
   assign w_memop_ex   = w_is_load_ex || mem_write_EX;

   lsu_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .chk_addr_lo (alu_res_EX[1:0]),
      .chk_funct3  (funct3_EX),
      .addr_lo     (r_alu_res[1:0]),
      .funct3      (r_funct3),
      .store_data  (r_store_data),
      .rsp_rdata   (dmem_rsp_rdata),
      .misaligned  (w_mis_ex),
      .wstrb       (w_wstrb),
      .wdata       (w_wdata),
      .load_data   (w_load_data)
   );

   // EX/MEM capture; a flush loads a bubble with no memory operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_res    <= '0;
         r_store_data <= '0;
         r_rd         <= '0;
         r_reg_write  <= 1'b0;
         r_result_sel <= c_res_alu;
         r_pc4        <= '0;
         r_funct3     <= 3'd0;
         r_is_load    <= 1'b0;
         r_is_store   <= 1'b0;
         r_misaligned <= 1'b0;
      end else if (w_capture) begin
         r_alu_res    <= alu_res_EX;
         r_store_data <= write_data_EX;
         r_rd         <= rd_EX;
         r_pc4        <= PC_plus_4_EX;
         r_funct3     <= funct3_EX;
         if (flush_EX_MEM) begin
            r_reg_write  <= 1'b0;
            r_result_sel <= c_res_alu;
            r_is_load    <= 1'b0;
            r_is_store   <= 1'b0;
            r_misaligned <= 1'b0;
         end else begin
            r_reg_write  <= reg_write_EX && !(w_memop_ex && w_mis_ex);
            r_result_sel <= result_sel_EX;
            r_is_load    <= w_is_load_ex;
            r_is_store   <= mem_write_EX;
            r_misaligned <= w_memop_ex && w_mis_ex;
         end
      end
   end

   // Next-state decode for the memory access sequencer
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle, c_st_done: begin
            if (flush_EX_MEM || !w_memop_ex)
               w_state_next = c_st_idle;
            else if (w_mis_ex)
               w_state_next = c_st_done;
            else
               w_state_next = c_st_req;
         end
         c_st_req: begin
            if (dmem_req_ready)
               w_state_next = r_is_store ? c_st_done : c_st_wait;
         end
         c_st_wait: begin
            if (dmem_rsp_valid)
               w_state_next = c_st_done;
         end
         default: w_state_next = c_st_idle;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= c_st_idle;
      else
         r_state <= w_state_next;
   end

   // Load result is taken only from a response that arrives in WAIT_RSP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_load_data <= '0;
      else if ((r_state == c_st_wait) && dmem_rsp_valid)
         r_load_data <= w_load_data;
   end

   assign alu_res_EX_MEM_o    = r_alu_res;
   assign rd_EX_MEM_o         = r_rd;
   assign reg_write_EX_MEM_o  = r_reg_write;
   assign result_sel_EX_MEM_o = r_result_sel;
   assign PC_plus_4_EX_MEM_o  = r_pc4;
   assign load_data_MEM       = r_load_data;
   assign misaligned_MEM      = r_misaligned;
   assign stall_mem           = w_stall;

   // Request fields are zero outside REQ so the bus is quiet when idle
   assign dmem_req_valid = w_req;
   assign dmem_req_we    = w_req && r_is_store;
   assign dmem_req_addr  = w_req ? {r_alu_res[DATA_ADDR_WIDTH-1:2], 2'b00} : '0;
   assign dmem_req_wdata = (w_req && r_is_store) ? w_wdata : '0;
   assign dmem_req_wstrb = (w_req && r_is_store) ? w_wstrb : 4'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_mem_stage_lsu                                     |
// | Description : Self-checking bench for mem_stage_lsu: directed      |
// |               cases followed by random instructions checked        |
// |               against an arithmetic reference model.               |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] alu_res_EX, write_data_EX, PC_plus_4_EX;
   logic [4:0]  rd_EX;
   logic        reg_write_EX, mem_write_EX, flush_EX_MEM;
   logic [1:0]  result_sel_EX;
   logic [2:0]  funct3_EX;
   logic [31:0] alu_res_EX_MEM_o, PC_plus_4_EX_MEM_o, load_data_MEM;
   logic [4:0]  rd_EX_MEM_o;
   logic        reg_write_EX_MEM_o, misaligned_MEM, stall_mem;
   logic [1:0]  result_sel_EX_MEM_o;
   logic        dmem_req_valid, dmem_req_ready, dmem_req_we, dmem_rsp_valid;
   logic [31:0] dmem_req_addr, dmem_req_wdata, dmem_rsp_rdata;
   logic [3:0]  dmem_req_wstrb;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_ld = 32'd0;

   always #5 clk = ~clk;

   mem_stage_lsu dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .alu_res_EX          (alu_res_EX),
      .write_data_EX       (write_data_EX),
      .rd_EX               (rd_EX),
      .reg_write_EX        (reg_write_EX),
      .mem_write_EX        (mem_write_EX),
      .result_sel_EX       (result_sel_EX),
      .funct3_EX           (funct3_EX),
      .PC_plus_4_EX        (PC_plus_4_EX),
      .flush_EX_MEM        (flush_EX_MEM),
      .alu_res_EX_MEM_o    (alu_res_EX_MEM_o),
      .rd_EX_MEM_o         (rd_EX_MEM_o),
      .reg_write_EX_MEM_o  (reg_write_EX_MEM_o),
      .result_sel_EX_MEM_o (result_sel_EX_MEM_o),
      .PC_plus_4_EX_MEM_o  (PC_plus_4_EX_MEM_o),
      .load_data_MEM       (load_data_MEM),
      .misaligned_MEM      (misaligned_MEM),
      .stall_mem           (stall_mem),
      .dmem_req_valid      (dmem_req_valid),
      .dmem_req_ready      (dmem_req_ready),
      .dmem_req_we         (dmem_req_we),
      .dmem_req_addr       (dmem_req_addr),
      .dmem_req_wdata      (dmem_req_wdata),
      .dmem_req_wstrb      (dmem_req_wstrb),
      .dmem_rsp_valid      (dmem_rsp_valid),
      .dmem_rsp_rdata      (dmem_rsp_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: extracted and extended load value from lane arithmetic
   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rdata);
      int unsigned sh;
      logic [31:0] v;
      sh = 8 * (a % 4);
      case (f3)
         3'd0: begin v = (rdata >> sh) & 32'hFF;   if (v >= 32'h80)   v = v + 32'hFFFFFF00; end
         3'd4: v = (rdata >> sh) & 32'hFF;
         3'd1: begin v = (rdata >> sh) & 32'hFFFF; if (v >= 32'h8000) v = v + 32'hFFFF0000; end
         3'd5: v = (rdata >> sh) & 32'hFFFF;
         default: v = rdata;
      endcase
      return v;
   endfunction

   function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
      if (f3 == 3'd0) return 4'(1 << (a % 4));
      if (f3 == 3'd1) return 4'(3 << (a % 4));
      return 4'hF;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
      if (f3 == 3'd0) return (d % 256) * 32'h01010101;
      if (f3 == 3'd1) return (d % 65536) * 32'h00010001;
      return d;
   endfunction

   // Present one instruction, play the memory side, and check everything observable
   task automatic run_op(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc4,
                         input logic [4:0] rd, input logic rw, input logic mw, input logic fl,
                         input logic [1:0] rs, input logic [2:0] f3,
                         input int rdy_wait, input int rsp_wait, input logic [31:0] rdata,
                         input logic spur);
      logic is_load, memop, mis;
      is_load = (rs == 2'b01);
      memop   = !fl && (is_load || mw);
      mis     = memop && (((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) ||
                          ((f3 == 3'd2) && (a % 4 != 0)));
      alu_res_EX = a; write_data_EX = wd; PC_plus_4_EX = pc4; rd_EX = rd;
      reg_write_EX = rw; mem_write_EX = mw; flush_EX_MEM = fl;
      result_sel_EX = rs; funct3_EX = f3;
      @(negedge clk);
      chk("alu_res", alu_res_EX_MEM_o, a);
      chk("rd", {27'd0, rd_EX_MEM_o}, {27'd0, rd});
      chk("pc4", PC_plus_4_EX_MEM_o, pc4);
      chk("reg_write", {31'd0, reg_write_EX_MEM_o}, {31'd0, (!fl && !mis && rw)});
      chk("result_sel", {30'd0, result_sel_EX_MEM_o}, {30'd0, (fl ? 2'b00 : rs)});
      chk("misaligned", {31'd0, misaligned_MEM}, {31'd0, mis});
      if (memop && !mis) begin
         for (int i = 0; i <= rdy_wait; i++) begin
            chk("req_stall", {31'd0, stall_mem}, 32'd1);
            chk("req_valid", {31'd0, dmem_req_valid}, 32'd1);
            chk("req_addr", dmem_req_addr, a - (a % 4));
            chk("req_we", {31'd0, dmem_req_we}, {31'd0, mw});
            if (mw) begin
               chk("req_wstrb", {28'd0, dmem_req_wstrb}, {28'd0, ref_strb(f3, a)});
               chk("req_wdata", dmem_req_wdata, ref_wdata(f3, wd));
            end
            dmem_req_ready = (i == rdy_wait);
            dmem_rsp_valid = spur && ($urandom_range(0, 1) == 1);
            dmem_rsp_rdata = $urandom;
            alu_res_EX = $urandom; rd_EX = 5'($urandom); flush_EX_MEM = 1'($urandom);
            @(negedge clk);
            chk("frozen_alu", alu_res_EX_MEM_o, a);
            chk("frozen_rd", {27'd0, rd_EX_MEM_o}, {27'd0, rd});
         end
         dmem_req_ready = 1'b0;
         dmem_rsp_valid = 1'b0;
         if (!mw) begin
            for (int j = 0; j < rsp_wait; j++) begin
               chk("wait_stall", {31'd0, stall_mem}, 32'd1);
               chk("wait_valid", {31'd0, dmem_req_valid}, 32'd0);
               @(negedge clk);
            end
            chk("wait_stall", {31'd0, stall_mem}, 32'd1);
            dmem_rsp_valid = 1'b1;
            dmem_rsp_rdata = rdata;
            @(negedge clk);
            dmem_rsp_valid = 1'b0;
            exp_ld = ref_load(f3, a, rdata);
         end
      end else if (spur) begin
         dmem_rsp_valid = 1'b1;
         dmem_rsp_rdata = $urandom;
         chk("idle_valid", {31'd0, dmem_req_valid}, 32'd0);
         @(negedge clk);
         dmem_rsp_valid = 1'b0;
      end
      chk("done_stall", {31'd0, stall_mem}, 32'd0);
      chk("done_valid", {31'd0, dmem_req_valid}, 32'd0);
      chk("load_data", load_data_MEM, exp_ld);
   endtask

   initial begin
      rst_n = 1'b0;
      alu_res_EX = 0; write_data_EX = 0; PC_plus_4_EX = 0; rd_EX = 0;
      reg_write_EX = 0; mem_write_EX = 0; flush_EX_MEM = 0;
      result_sel_EX = 0; funct3_EX = 0;
      dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_rdata = 0;
      repeat (2) @(negedge clk);
      chk("rst_alu", alu_res_EX_MEM_o, 32'd0);
      chk("rst_rw", {31'd0, reg_write_EX_MEM_o}, 32'd0);
      chk("rst_rs", {30'd0, result_sel_EX_MEM_o}, 32'd0);
      chk("rst_ld", load_data_MEM, 32'd0);
      chk("rst_stall", {31'd0, stall_mem}, 32'd0);
      chk("rst_valid", {31'd0, dmem_req_valid}, 32'd0);
      chk("rst_wstrb", {28'd0, dmem_req_wstrb}, 32'd0);
      rst_n = 1'b1;

      // SW, SB, LB/LBU, slow LW, misaligned LH
      run_op(32'h100, 32'hDEADBEEF, 32'h4, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 3'd2, 0, 0, 0, 1'b0);
      run_op(32'h103, 32'h000000A5, 32'h8, 5'd0, 1'b0, 1'b1, 1'b0, 2'b00, 3'd0, 0, 0, 0, 1'b0);
      run_op(32'h102, 32'h0, 32'hC, 5'd3, 1'b1, 1'b0, 1'b0, 2'b01, 3'd0, 0, 0, 32'h0080FF00, 1'b0);
      chk("lb_literal", load_data_MEM, 32'hFFFFFF80);
      run_op(32'h102, 32'h0, 32'h10, 5'd4, 1'b1, 1'b0, 1'b0, 2'b01, 3'd4, 0, 0, 32'h0080FF00, 1'b0);
      chk("lbu_literal", load_data_MEM, 32'h00000080);
      run_op(32'h104, 32'h0, 32'h14, 5'd5, 1'b1, 1'b0, 1'b0, 2'b01, 3'd2, 3, 2, 32'hCAFEF00D, 1'b1);
      run_op(32'h101, 32'h0, 32'h18, 5'd6, 1'b1, 1'b0, 1'b0, 2'b01, 3'd1, 0, 0, 0, 1'b0);
      chk("lh_mis_literal", {31'd0, misaligned_MEM}, 32'd1);

      // Random instruction mix
      for (int k = 0; k < 300; k++) begin
         logic [2:0]  f3;
         logic [1:0]  rs;
         logic        mw, fl;
         int          kind;
         kind = $urandom_range(0, 3);
         fl   = ($urandom_range(0, 7) == 0);
         mw   = (kind == 1);
         if (kind == 0) begin
            rs = 2'b01;
            case ($urandom_range(0, 4))
               0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
            endcase
         end else begin
            rs = (kind == 3) ? 2'b10 : 2'b00;
            f3 = 3'($urandom_range(0, 2));
         end
         run_op($urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), mw, fl, rs, f3,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom));
      end

      // Reset while waiting for a load response; the late response must be ignored
      alu_res_EX = 32'h200; mem_write_EX = 0; flush_EX_MEM = 0;
      result_sel_EX = 2'b01; funct3_EX = 3'd2; reg_write_EX = 1;
      @(negedge clk);
      dmem_req_ready = 1'b1;
      @(negedge clk);
      dmem_req_ready = 1'b0;
      chk("pre_rst_stall", {31'd0, stall_mem}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, dmem_req_valid}, 32'd0);
      chk("mid_rst_stall", {31'd0, stall_mem}, 32'd0);
      chk("mid_rst_alu", alu_res_EX_MEM_o, 32'd0);
      chk("mid_rst_rw", {31'd0, reg_write_EX_MEM_o}, 32'd0);
      chk("mid_rst_ld", load_data_MEM, 32'd0);
      flush_EX_MEM = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      dmem_rsp_valid = 1'b1;
      dmem_rsp_rdata = 32'h12345678;
      @(negedge clk);
      dmem_rsp_valid = 1'b0;
      chk("late_rsp_ld", load_data_MEM, 32'd0);
      chk("late_rsp_stall", {31'd0, stall_mem}, 32'd0);
      chk("late_rsp_valid", {31'd0, dmem_req_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
